yfcpu_param: RTL and testbench

YFCPU_PARAM -- requirements
Module: yfcpu_param

---
 rtl/yfcpu_pkg.sv | 54 +++++
 rtl/yfcpu_alu.sv | 41 ++++
 rtl/yfcpu_param.sv | 161 ++++++++++++++++
 tb/tb_yfcpu_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yfcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : yfcpu_pkg
// Description : Shared constants for the parameterised YFCPU: opcode values,
//               FSM state encoding, fixed field widths and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package yfcpu_pkg;

    // Fixed field widths; register-address fields scale with RF_AW
    localparam int c_OP_W = 4;
    localparam int c_ST_W = 3;

    // FSM state encoding
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_FETCH  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_DECODE = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_EXEC   = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_STORE  = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_HALT   = 3'd5;

    // Opcodes
    localparam logic [c_OP_W-1:0] c_OP_HALT = 4'h0;
    localparam logic [c_OP_W-1:0] c_OP_LRI  = 4'h1;
    localparam logic [c_OP_W-1:0] c_OP_SUB  = 4'h3;
    localparam logic [c_OP_W-1:0] c_OP_ADD  = 4'h4;
    localparam logic [c_OP_W-1:0] c_OP_AND  = 4'h5;
    localparam logic [c_OP_W-1:0] c_OP_OR   = 4'h6;
    localparam logic [c_OP_W-1:0] c_OP_XOR  = 4'h7;
    localparam logic [c_OP_W-1:0] c_OP_SHL  = 4'h8;
    localparam logic [c_OP_W-1:0] c_OP_SHR  = 4'h9;
    localparam logic [c_OP_W-1:0] c_OP_BEQZ = 4'hA;
    localparam logic [c_OP_W-1:0] c_OP_JMP  = 4'hB;
    localparam logic [c_OP_W-1:0] c_OP_NOP  = 4'hC;

    // Opcodes that produce a register result and therefore take a STORE cycle
    function automatic logic op_writes(input logic [c_OP_W-1:0] op);
        case (op)
            c_OP_LRI, c_OP_SUB, c_OP_ADD, c_OP_AND, c_OP_OR,
            c_OP_XOR, c_OP_SHL, c_OP_SHR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Opcodes that complete in EXEC without a register write
    function automatic logic op_ctrl(input logic [c_OP_W-1:0] op);
        case (op)
            c_OP_HALT, c_OP_BEQZ, c_OP_JMP, c_OP_NOP: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/yfcpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : yfcpu_alu
// Description : Combinational ALU for YFCPU. Arithmetic wraps modulo 2^DW;
//               shifts are logical with the amount taken modulo DW.
// Revision    : 1.0 - initial release
// ============================================================================
module yfcpu_alu
    import yfcpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [c_OP_W-1:0] op,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic [DW-1:0]     result
);

    // DW expressed at operand width so the modulo stays width-matched
    localparam logic [DW-1:0] c_DW_MOD = DW'(DW);

    logic [DW-1:0] w_shamt;
    assign w_shamt = b % c_DW_MOD;

    // Operation select; non-ALU opcodes yield zero
    always_comb begin
        result = '0;
        case (op)
            c_OP_ADD: result = a + b;
            c_OP_SUB: result = a - b;
            c_OP_AND: result = a & b;
            c_OP_OR:  result = a | b;
            c_OP_XOR: result = a ^ b;
            c_OP_SHL: result = a << w_shamt;
            c_OP_SHR: result = a >> w_shamt;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/yfcpu_param.sv
`default_nettype none
// ============================================================================
// Module      : yfcpu_param
// Description : Parameterised multi-cycle CPU. FETCH/DECODE/EXEC/STORE
//               sequencing, 2^RF_AW register file with R0 hardwired to zero,
//               2^IM_AW-word instruction memory loadable while idle/halted.
// Revision    : 1.0 - initial release
// ============================================================================
module yfcpu_param
    import yfcpu_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RF_AW = 4,
    parameter int IM_AW = 8,
    localparam int IW   = c_OP_W + 3 * RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_we,
    input  logic [IM_AW-1:0] imem_waddr,
    input  logic [IW-1:0]    imem_wdata,
    input  logic             run,
    input  logic [RF_AW-1:0] dbg_raddr,
    output logic [DW-1:0]    dbg_rdata,
    output logic [IM_AW-1:0] pc_out,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic             retired
);

    localparam int c_NREG = 2 ** RF_AW;
    localparam int c_NIM  = 2 ** IM_AW;

    logic [c_ST_W-1:0] r_state;
    logic [IM_AW-1:0]  r_pc;
    logic [IW-1:0]     r_ir;
    logic [DW-1:0]     r_result;
    logic              r_err;
    logic              r_retired;
    logic [DW-1:0]     r_rf   [c_NREG];
    logic [IW-1:0]     r_imem [c_NIM];

    // Instruction fields, MSB first: OP, RA, RB, RD
    logic [c_OP_W-1:0] w_op;
    logic [RF_AW-1:0]  w_ra;
    logic [RF_AW-1:0]  w_rb;
    logic [RF_AW-1:0]  w_rd;
    assign w_op = r_ir[IW-1 -: c_OP_W];
    assign w_ra = r_ir[3*RF_AW-1 -: RF_AW];
    assign w_rb = r_ir[2*RF_AW-1 -: RF_AW];
    assign w_rd = r_ir[RF_AW-1:0];

    logic [DW-1:0]    w_a;
    logic [DW-1:0]    w_b;
    logic [DW-1:0]    w_alu;
    logic [DW-1:0]    w_lri;
    logic [IM_AW-1:0] w_beqz_tgt;
    logic [IM_AW-1:0] w_jmp_tgt;
    logic             w_imem_open;

    assign w_a        = r_rf[w_ra];
    assign w_b        = r_rf[w_rb];
    assign w_lri      = DW'({w_ra, w_rb});
    assign w_beqz_tgt = IM_AW'({w_rb, w_rd});
    assign w_jmp_tgt  = IM_AW'({w_ra, w_rb, w_rd});
    assign w_imem_open = (r_state == c_ST_IDLE) || (r_state == c_ST_HALT);

    yfcpu_alu #(
        .DW (DW)
    ) u_alu (
        .op     (w_op),
        .a      (w_a),
        .b      (w_b),
        .result (w_alu)
    );

    // Instruction memory load port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && imem_we && w_imem_open) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    // Sequencer: state, PC, IR, register file and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_retired <= 1'b0;
            for (int i = 0; i < c_NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_retired <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_HALT: begin
                    if (run) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_ir    <= r_imem[r_pc];
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_pc      <= r_pc + IM_AW'(1);
                    r_state   <= c_ST_EXEC;
                    // Control ops retire during EXEC, so raise the pulse now
                    r_retired <= op_ctrl(w_op);
                end
                c_ST_EXEC: begin
                    if (op_writes(w_op)) begin
                        r_result  <= (w_op == c_OP_LRI) ? w_lri : w_alu;
                        r_state   <= c_ST_STORE;
                        r_retired <= 1'b1;
                    end else begin
                        case (w_op)
                            c_OP_HALT: r_state <= c_ST_HALT;
                            c_OP_BEQZ: begin
                                if (w_a == '0) begin
                                    r_pc <= w_beqz_tgt;
                                end
                                r_state <= c_ST_FETCH;
                            end
                            c_OP_JMP: begin
                                r_pc    <= w_jmp_tgt;
                                r_state <= c_ST_FETCH;
                            end
                            c_OP_NOP: r_state <= c_ST_FETCH;
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= c_ST_HALT;
                            end
                        endcase
                    end
                end
                c_ST_STORE: begin
                    if (w_rd != '0) begin
                        r_rf[w_rd] <= r_result;
                    end
                    r_state <= c_ST_FETCH;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_rf[dbg_raddr];
    assign pc_out    = r_pc;
    assign busy      = (r_state == c_ST_FETCH) || (r_state == c_ST_DECODE) ||
                       (r_state == c_ST_EXEC)  || (r_state == c_ST_STORE);
    assign halted    = (r_state == c_ST_HALT);
    assign err       = r_err;
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_yfcpu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_yfcpu_param
// Description : Directed self-checking bench for yfcpu_param (DW=16,
//               RF_AW=4, IM_AW=8). Expected PC at each retirement is queued
//               by the stimulus and checked by a retirement monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yfcpu_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic        run = 1'b0;
    logic [3:0]  dbg_raddr = '0;
    logic [15:0] dbg_rdata;
    logic [7:0]  pc_out;
    logic        busy;
    logic        halted;
    logic        err;
    logic        retired;

    int checks = 0;
    int errors = 0;
    int n_retired = 0;
    logic [7:0] exp_q[$];

    yfcpu_param #(
        .DW    (16),
        .RF_AW (4),
        .IM_AW (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .run        (run),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc_out     (pc_out),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
        return {op, ra, rb, rd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Retirement monitor: every pulse must match the next queued PC
    always @(negedge clk) begin
        if (retired) begin
            n_retired++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected actual_pc=%0h required=no_retire", pc_out);
            end else begin
                check("retire_pc", {24'd0, pc_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] word);
        @(negedge clk);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = word;
        @(negedge clk) imem_we = 1'b0;
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int exp_cycles);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=not_halted required=halted", name);
        end else if (exp_cycles >= 0) begin
            check({name, "_cycles"}, n, exp_cycles);
        end
    endtask

    task automatic check_reg(input string name, input logic [3:0] r, input logic [15:0] exp);
        dbg_raddr = r;
        #1;
        check(name, {16'd0, dbg_rdata}, {16'd0, exp});
    endtask

    task automatic check_q_empty(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;

        // Reset state
        do_reset();
        check("rst_pc", pc_out, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);

        // LRI/LRI/ADD/HALT -> R3 = 15
        load(8'h00, enc(4'h1, 4'h0, 4'h4, 4'h1));
        load(8'h01, enc(4'h1, 4'h0, 4'hB, 4'h2));
        load(8'h02, enc(4'h4, 4'h1, 4'h2, 4'h3));
        load(8'h03, enc(4'h0, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        base = n_retired;
        pulse_run();
        wait_halt("add", 15);
        check_reg("add_r3", 4'd3, 16'd15);
        check("add_halted", halted, 1);
        check("add_busy", busy, 0);
        check("add_pc", pc_out, 8'h04);
        check("add_retired_count", n_retired - base, 4);
        check_q_empty("add_q_empty");

        // SUB wraps: 3 - 5 = 0xFFFE
        do_reset();
        load(8'h00, enc(4'h1, 4'h0, 4'h3, 4'h1));
        load(8'h01, enc(4'h1, 4'h0, 4'h5, 4'h2));
        load(8'h02, enc(4'h3, 4'h1, 4'h2, 4'h3));
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        pulse_run();
        wait_halt("sub", 15);
        check_reg("sub_r3", 4'd3, 16'hFFFE);
        check_q_empty("sub_q_empty");

        // BEQZ taken: R1 == 0 -> 0x20, HALT there
        do_reset();
        load(8'h00, enc(4'hA, 4'h1, 4'h2, 4'h0));
        load(8'h20, enc(4'h0, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01, 8'h21};
        pulse_run();
        wait_halt("beqz_taken", 6);
        check("beqz_taken_pc", pc_out, 8'h21);
        check_q_empty("beqz_taken_q_empty");

        // BEQZ not taken: R1 = 1 falls through to HALT at 2
        do_reset();
        load(8'h00, enc(4'h1, 4'h0, 4'h1, 4'h1));
        load(8'h01, enc(4'hA, 4'h1, 4'h2, 4'h0));
        load(8'h02, enc(4'h0, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01, 8'h02, 8'h03};
        pulse_run();
        wait_halt("beqz_fall", 10);
        check("beqz_fall_pc", pc_out, 8'h03);
        check_q_empty("beqz_fall_q_empty");

        // Write to R0 discarded; illegal opcode 0xF sets err with no retire
        do_reset();
        load(8'h00, enc(4'h1, 4'hF, 4'hF, 4'h0));
        load(8'h01, enc(4'hF, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01};
        base = n_retired;
        pulse_run();
        wait_halt("illegal", 7);
        check_reg("r0_zero", 4'd0, 16'h0000);
        check("illegal_err", err, 1);
        check("illegal_halted", halted, 1);
        check("illegal_retired_count", n_retired - base, 1);
        check_q_empty("illegal_q_empty");

        // Reset during EXEC of ADD aborts it
        do_reset();
        check("err_cleared", err, 0);
        load(8'h00, enc(4'h1, 4'h0, 4'h7, 4'h1));
        load(8'h01, enc(4'h4, 4'h1, 4'h1, 4'h2));
        exp_q = '{8'h01};
        pulse_run();
        repeat (6) @(negedge clk);
        check_reg("abort_r1_before", 4'd1, 16'd7);
        check("abort_in_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_pc", pc_out, 0);
        check("abort_busy", busy, 0);
        check("abort_halted", halted, 0);
        check_reg("abort_r2", 4'd2, 16'd0);
        repeat (4) @(negedge clk);
        check_reg("abort_r2_later", 4'd2, 16'd0);
        check_q_empty("abort_q_empty");

        // imem_we while busy is ignored
        do_reset();
        load(8'h00, enc(4'h1, 4'h0, 4'h9, 4'h1));
        load(8'h01, enc(4'h0, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01, 8'h02};
        pulse_run();
        imem_we    = 1'b1;
        imem_waddr = 8'h01;
        imem_wdata = enc(4'h1, 4'h0, 4'h5, 4'h2);
        repeat (3) @(negedge clk);
        imem_we = 1'b0;
        wait_halt("we_busy", -1);
        check_reg("we_busy_r1", 4'd1, 16'd9);
        check_reg("we_busy_r2", 4'd2, 16'd0);
        check("we_busy_pc", pc_out, 8'h02);
        check_q_empty("we_busy_q_empty");

        // JMP to 0xFF, NOP there, PC wraps to 0
        do_reset();
        load(8'h00, enc(4'hA, 4'h1, 4'h1, 4'h0));
        load(8'h01, enc(4'h0, 4'h0, 4'h0, 4'h0));
        load(8'h10, enc(4'h1, 4'h0, 4'h1, 4'h1));
        load(8'h11, enc(4'hB, 4'h0, 4'hF, 4'hF));
        load(8'hFF, enc(4'hC, 4'h0, 4'h0, 4'h0));
        exp_q = '{8'h01, 8'h11, 8'h12, 8'h00, 8'h01, 8'h02};
        pulse_run();
        wait_halt("wrap", 19);
        check("wrap_pc", pc_out, 8'h02);
        check("wrap_err", err, 0);
        check_q_empty("wrap_q_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
